fetch_stage: RTL

//  Instruction-fetch front end feeding the decode/register-read stage of the 16-bit pipelined core.
//  - Owns the PC and drives the synchronous-read I-memory.
//  - Buffers returned instructions in a small prefetch queue.
//  - Presents one registered {instr, pc, pc+1} per cycle to decode.
//  - Honours hazard stalls from hazard detection and branch/jump redirects from the control path.

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_queue.sv | 62 ++++++
 rtl/fetch_queue_checker.sv | 16 +
 rtl/fetch_stage.sv | 127 ++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_stage_pkg;

    localparam int ISIZE       = 16;
    localparam int FETCH_DEPTH = 2;

    typedef logic [ISIZE-1:0] word_t;

    localparam word_t FETCH_RESET_PC = 16'h0000;
    localparam word_t NOP_INSTR      = 16'h0000;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;

    function automatic word_t pc_inc(input word_t pc);
        return pc + word_t'(1'b1);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// I-memory request/response and decode-facing signals of the fetch stage.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    word_t imem_addr;
    word_t imem_rdata;
    logic  stall;
    logic  redirect;
    word_t redirect_pc;
    word_t id_instr;
    word_t id_pc;
    word_t id_pcplus1;
    logic  id_valid;

    modport master (
        output imem_addr, id_instr, id_pc, id_pcplus1, id_valid,
        input  imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_addr, id_instr, id_pc, id_pcplus1, id_valid,
        output imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of {instr, pc}; flush empties it in one cycle.
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               wr_data,
    output fetch_entry_t               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;

    // Entry storage; a push during flush is discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{instr: NOP_INSTR, pc: {ISIZE{1'b0}}};
            end
        end else if (push && !flush) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;
    assign empty   = (count_r == CW'(1'b0));
    assign full    = (count_r == CW'(DEPTH));
endmodule

// File: rtl/fetch_queue_checker.sv
// Occupancy invariants of the prefetch queue; the issue credit rule must keep these true.
module fetch_queue_checker (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic flush,
    input logic full,
    input logic empty
);
    overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !flush && full));

    underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && !flush && empty));
endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: owns the PC, issues I-memory reads under a queue credit rule,
// and presents one registered instruction per cycle to decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int    DEPTH    = FETCH_DEPTH,
    parameter word_t RESET_PC = FETCH_RESET_PC,
    parameter word_t NOP      = NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);

    word_t         fetch_pc_r;
    word_t         tag_r;
    logic          inflight_r;
    word_t         imem_addr_s;
    logic          issue_s;
    logic [CW-1:0] count_s;
    logic [CW-1:0] occupancy_s;
    logic          q_empty_s;
    logic          q_full_s;
    logic          load_s;
    logic          resp_s;
    logic          pop_s;
    logic          bypass_s;
    logic          push_s;
    fetch_entry_t  head_s;
    fetch_entry_t  resp_entry_s;
    logic          id_valid_r;
    word_t         id_instr_r;
    word_t         id_pc_r;
    word_t         id_pcplus1_r;

    // Issue only while queued plus in-flight words leave room, so responses never overflow
    always_comb begin
        occupancy_s = count_s + CW'(inflight_r);
        if (bus.redirect) begin
            imem_addr_s = bus.redirect_pc;
        end else begin
            imem_addr_s = fetch_pc_r;
        end
        issue_s = bus.redirect | (occupancy_s < CW'(DEPTH));
    end

    // Routing of the returning word: pop beats bypass, leftovers go to the queue
    always_comb begin
        resp_s       = inflight_r & ~bus.redirect;
        load_s       = ~bus.stall | ~id_valid_r;
        pop_s        = ~bus.redirect & load_s & ~q_empty_s;
        bypass_s     = ~bus.redirect & load_s & q_empty_s & resp_s;
        push_s       = resp_s & ~bypass_s;
        resp_entry_s = '{instr: bus.imem_rdata, pc: tag_r};
    end

    // PC and in-flight tag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r <= RESET_PC;
            tag_r      <= RESET_PC;
            inflight_r <= 1'b0;
        end else begin
            if (issue_s) begin
                fetch_pc_r <= pc_inc(imem_addr_s);
                tag_r      <= imem_addr_s;
            end
            inflight_r <= issue_s;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .rst_n   (rst),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (bus.redirect),
        .wr_data (resp_entry_s),
        .rd_data (head_s),
        .count   (count_s),
        .empty   (q_empty_s),
        .full    (q_full_s)
    );

    fetch_queue_checker u_queue_chk (
        .clk   (clk),
        .rst_n (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (bus.redirect),
        .full  (q_full_s),
        .empty (q_empty_s)
    );

    // Decode-facing register; redirect squashes it even while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid_r   <= 1'b0;
            id_instr_r   <= NOP;
            id_pc_r      <= {ISIZE{1'b0}};
            id_pcplus1_r <= {ISIZE{1'b0}};
        end else if (bus.redirect) begin
            id_valid_r <= 1'b0;
            id_instr_r <= NOP;
        end else if (pop_s) begin
            id_valid_r   <= 1'b1;
            id_instr_r   <= head_s.instr;
            id_pc_r      <= head_s.pc;
            id_pcplus1_r <= pc_inc(head_s.pc);
        end else if (bypass_s) begin
            id_valid_r   <= 1'b1;
            id_instr_r   <= resp_entry_s.instr;
            id_pc_r      <= resp_entry_s.pc;
            id_pcplus1_r <= pc_inc(resp_entry_s.pc);
        end else if (load_s) begin
            id_valid_r <= 1'b0;
            id_instr_r <= NOP;
        end
    end

    assign bus.imem_addr  = imem_addr_s;
    assign bus.id_valid   = id_valid_r;
    assign bus.id_instr   = id_instr_r;
    assign bus.id_pc      = id_pc_r;
    assign bus.id_pcplus1 = id_pcplus1_r;
endmodule
